// File: rtl/dmem_responder.sv
// Data-memory responder for the pipelined core's M-stage port: word RAM plus a small MMIO window
// holding a cycle counter, an output register, sticky error flags and a committed-write counter.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int          DEPTH   = 64,
  parameter logic [15:0] MMIO_HI = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic        we,
  output logic [31:0] rd,
  output logic [31:0] out_reg,
  output logic [3:0]  err_status,
  output logic        err_irq
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_OUT    = 8'h04;
  localparam logic [7:0] OFF_ERR    = 8'h08;
  localparam logic [7:0] OFF_CLEAR  = 8'h0C;
  localparam logic [7:0] OFF_WCOUNT = 8'h10;

  logic [31:0] mem [DEPTH];

  logic [31:0] cycleR;
  logic [31:0] outR;
  logic [31:0] wcountR;
  logic [3:0]  errR;
  logic        irqR;

  logic          isMmioS;
  logic          inRangeS;
  logic          misalignS;
  logic [7:0]    offS;
  logic [AW-1:0] ramIdxS;
  logic          ramWeS;
  logic          outWeS;
  logic          clrWeS;
  logic [3:0]    errSetS;
  logic [3:0]    errNextS;
  logic [31:0]   wcountNextS;
  logic [31:0]   rdS;

  // Address decode shared by the read mux and the write path; a[1:0] never selects a register.
  assign isMmioS   = (a[31:16] == MMIO_HI);
  assign inRangeS  = ({2'b00, a[31:2]} < DEPTH_W);
  assign misalignS = (a[1:0] != 2'b00);
  assign offS      = {a[7:2], 2'b00};
  assign ramIdxS   = a[AW+1:2];

  // Write decode: at most one action or one error bit per write, misalignment checked first.
  always_comb begin
    ramWeS  = 1'b0;
    outWeS  = 1'b0;
    clrWeS  = 1'b0;
    errSetS = 4'b0000;
    if (we) begin
      if (misalignS) begin
        errSetS = 4'b0001;
      end else if (isMmioS) begin
        case (offS)
          OFF_OUT:                       outWeS  = 1'b1;
          OFF_CLEAR:                     clrWeS  = 1'b1;
          OFF_CYCLE, OFF_ERR, OFF_WCOUNT: errSetS = 4'b0100;
          default:                       errSetS = 4'b1000;
        endcase
      end else if (inRangeS) begin
        ramWeS = 1'b1;
      end else begin
        errSetS = 4'b0010;
      end
    end else begin
      ramWeS = 1'b0;
    end
  end

  // Next error state and saturating write count; a clear write never raises an error itself.
  always_comb begin
    errNextS    = errR;
    wcountNextS = wcountR;
    if (clrWeS) begin
      errNextS = errR & ~wd[3:0];
    end else begin
      errNextS = errR | errSetS;
    end
    if (ramWeS && (wcountR != 32'hFFFF_FFFF)) begin
      wcountNextS = wcountR + 32'd1;
    end else begin
      wcountNextS = wcountR;
    end
  end

  // Combinational read mux.
  always_comb begin
    rdS = 32'd0;
    if (isMmioS) begin
      case (offS)
        OFF_CYCLE:  rdS = cycleR;
        OFF_OUT:    rdS = outR;
        OFF_ERR:    rdS = {28'd0, errR};
        OFF_WCOUNT: rdS = wcountR;
        default:    rdS = 32'd0;
      endcase
    end else if (inRangeS) begin
      rdS = mem[ramIdxS];
    end else begin
      rdS = 32'd0;
    end
  end

  // RAM array: never reset, and a write landing while reset is asserted is dropped.
  always_ff @(posedge clk) begin
    if (ramWeS && !reset) begin
      mem[ramIdxS] <= wd;
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleR  <= 32'd0;
      outR    <= 32'd0;
      wcountR <= 32'd0;
      errR    <= 4'b0000;
      irqR    <= 1'b0;
    end else begin
      cycleR  <= cycleR + 32'd1;
      wcountR <= wcountNextS;
      errR    <= errNextS;
      irqR    <= |errNextS;
      if (outWeS) begin
        outR <= wd;
      end
    end
  end

  assign rd         = rdS;
  assign out_reg    = outR;
  assign err_status = errR;
  assign err_irq    = irqR;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a reference model predicts read data, expectations are
// queued when a read is driven and compared once rd has settled.
`timescale 1ns/1ps
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] a;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;
  logic [31:0] out_reg;
  logic [3:0]  err_status;
  logic        err_irq;

  dmem_responder #(.DEPTH(64), .MMIO_HI(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .a(a), .wd(wd), .we(we),
    .rd(rd), .out_reg(out_reg), .err_status(err_status), .err_irq(err_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int nCompared = 0;
  int nMismatched = 0;

  logic [31:0] ramM [64];
  logic [31:0] outM;
  logic [31:0] wcountM;
  logic [3:0]  errM;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pushExp(input string tag, input logic [31:0] exp);
    sbEntry_t e;
    e.tag = tag;
    e.exp = exp;
    sbQ.push_back(e);
  endtask

  task automatic drainSb();
    sbEntry_t e;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checkVal(e.tag, rd, e.exp);
    end
  endtask

  task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data);
    if (addr[1:0] != 2'b00) begin
      errM = errM | 4'b0001;
    end else if (addr[31:16] == 16'hFFFF) begin
      case (addr[7:0])
        8'h04: outM = data;
        8'h0C: errM = errM & ~data[3:0];
        8'h00, 8'h08, 8'h10: errM = errM | 4'b0100;
        default: errM = errM | 4'b1000;
      endcase
    end else if (addr[31:2] < 30'd64) begin
      ramM[addr[7:2]] = data;
      if (wcountM != 32'hFFFF_FFFF) wcountM = wcountM + 32'd1;
    end else begin
      errM = errM | 4'b0010;
    end
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    a = addr; wd = data; we = 1'b1;
    @(posedge clk);
    modelWrite(addr, data);
    #1;
    we = 1'b0;
  endtask

  task automatic doRead(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    @(negedge clk);
    a = addr; we = 1'b0;
    pushExp(tag, exp);
    #1;
    drainSb();
  endtask

  task automatic checkStatus(input string tag);
    checkVal({tag, "_err"}, {28'd0, err_status}, {28'd0, errM});
    checkVal({tag, "_irq"}, {31'd0, err_irq}, {31'd0, (errM != 4'b0000)});
    checkVal({tag, "_out"}, out_reg, outM);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; a = 32'd0; wd = 32'd0;
    outM = 32'd0; wcountM = 32'd0; errM = 4'b0000;
    #1;
    checkStatus("rst");
    @(negedge clk);
    reset = 1'b0;

    // write then read back; WCOUNT reflects one committed write
    doWrite(32'h0000_0010, 32'hDEAD_BEEF);
    doRead("t1_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    doRead("t1_wcount", 32'hFFFF_0010, 32'd1);

    // rd still shows the old word during the write cycle
    @(negedge clk);
    a = 32'h0000_0010; wd = 32'h1234_5678; we = 1'b1;
    pushExp("t1_old", 32'hDEAD_BEEF);
    #1;
    drainSb();
    @(posedge clk);
    modelWrite(32'h0000_0010, 32'h1234_5678);
    #1;
    we = 1'b0;
    doRead("t1_new", 32'h0000_0013, 32'h1234_5678);

    // misaligned write and W1C clear
    doWrite(32'h0000_0012, 32'd5);
    doRead("t2_ram4", 32'h0000_0010, ramM[4]);
    checkVal("t2_err", {28'd0, err_status}, 32'h0000_0001);
    checkVal("t2_irq", {31'd0, err_irq}, 32'd1);
    doWrite(32'hFFFF_000C, 32'h0000_0001);
    checkStatus("t2_clr");

    // range, read-only and unmapped errors, then misaligned MMIO write
    doWrite(32'h0000_0100, 32'h0000_0055);
    checkVal("t3_range", {28'd0, err_status}, 32'h0000_0002);
    doRead("t3_rd_oor", 32'h0000_0100, 32'd0);
    doWrite(32'hFFFF_0000, 32'h0000_0077);
    checkVal("t3_ro", {28'd0, err_status}, 32'h0000_0006);
    doWrite(32'hFFFF_0020, 32'h0000_0077);
    checkVal("t3_unmap", {28'd0, err_status}, 32'h0000_000E);
    doWrite(32'hFFFF_0006, 32'h0000_0077);
    doRead("t3_errreg", 32'hFFFF_0008, 32'h0000_000F);
    doWrite(32'hFFFF_000C, 32'h0000_0005);
    checkStatus("t3_part");
    doWrite(32'hFFFF_000C, 32'hFFFF_FFFF);
    checkStatus("t3_all");
    doRead("t3_clrreg", 32'hFFFF_000C, 32'd0);
    doRead("t3_mmio_other", 32'hFFFF_0040, 32'd0);

    // OUT register
    doWrite(32'hFFFF_0004, 32'h0000_00A5);
    checkVal("t5_out", out_reg, 32'h0000_00A5);
    doRead("t5_outrd", 32'hFFFF_0004, 32'h0000_00A5);

    // back-to-back writes and the last in-range word
    doWrite(32'h0000_0000, 32'h1111_0001);
    doWrite(32'h0000_0004, 32'h2222_0002);
    doWrite(32'h0000_0008, 32'h3333_0003);
    doRead("t6_w0", 32'h0000_0000, 32'h1111_0001);
    doRead("t6_w1", 32'h0000_0004, 32'h2222_0002);
    doRead("t6_w2", 32'h0000_0008, 32'h3333_0003);
    doRead("t6_wcount", 32'hFFFF_0010, wcountM);
    doWrite(32'h0000_00FC, 32'hCAFE_F00D);
    doRead("t6_last", 32'h0000_00FC, 32'hCAFE_F00D);
    doWrite(32'h0000_0100, 32'hBAD0_BAD0);
    checkStatus("t6_oor");
    doRead("t6_wcount2", 32'hFFFF_0010, 32'd6);

    // async reset mid-cycle clears registers at once; write under reset is dropped
    @(negedge clk);
    a = 32'hFFFF_0000;
    #2;
    reset = 1'b1;
    outM = 32'd0; wcountM = 32'd0; errM = 4'b0000;
    pushExp("t4_cyc_rst", 32'd0);
    #1;
    drainSb();
    checkStatus("t4_rst");
    @(negedge clk);
    a = 32'h0000_0010; wd = 32'h0BAD_0BAD; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    doRead("t4_cycle", 32'hFFFF_0000, 32'd10);
    doRead("t4_ram_kept", 32'h0000_0010, 32'h1234_5678);
    doRead("t4_wcount", 32'hFFFF_0010, 32'd0);

    checkVal("sb_empty", 32'(sbQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
